score_playback_reader: RTL and testbench

Playback sequencer that reads a recorded score back out of the note memory filled by the recorder, one entry per beat. It outputs the current 6-bit key code to the key decoder/PWM tone path. It also outputs the beat index for the VGA score display. It is the read-side counterpart of the record path and shares its address width, key-code encoding and beat tick.

---
 rtl/score_playback_reader_if.sv | 25 ++
 rtl/score_playback_reader.sv | 172 +++++++++++++++++
 tb/tb_score_playback_reader.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/score_playback_reader_if.sv
// -----------------------------------------------------------------------------
// score_playback_reader_if
//
// Read port of the score note memory, shared by the playback reader (master)
// and the synchronous RAM (slave).
//
// Signals:
//   rd_addr  ADDR_W  read address, driven by the reader
//   rd_data  KEY_W   read data, driven by the RAM
//
// Handshake: this port has no valid/ready pair. It is a fixed-latency
// read. The RAM samples rd_addr on a rising clock edge, and rd_data holds
// mem[rd_addr] for the whole following cycle. The reader keeps rd_addr
// stable for the cycle before it captures rd_data.
// -----------------------------------------------------------------------------
interface score_playback_reader_if #(
  parameter int ADDR_W = 9,
  parameter int KEY_W  = 6
);
  logic [ADDR_W-1:0] rd_addr;
  logic [KEY_W-1:0]  rd_data;

  modport master (output rd_addr, input rd_data);
  modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/score_playback_reader.sv
// -----------------------------------------------------------------------------
// score_playback_reader
//
// Playback sequencer for a recorded score. It advances through the note memory
// by one entry per beat and sends the current key code to the tone path. It
// also sends the beat index to the score display.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-low reset
//   play       level: high = play, low = stop/abort
//   beat       beat square wave; each rising edge advances the score
//   mem        score memory read port (master side: rd_addr out, rd_data in)
//   key_out    registered key code currently sounding (0 = rest)
//   beat_num   index of the entry held in key_out
//   playing    high in FETCH, CAPT, HOLD
//   done       high in DONE
//   state_dbg  current FSM state, for debug and checkers
//
// Build option:
//   SCORE_LOOP_EN  when defined, an advance past LAST_ADDR wraps to address 0.
//                  When undefined, the same advance ends playback in DONE.
//                  An END_CODE entry ends playback in both builds.
// -----------------------------------------------------------------------------
module score_playback_reader #(
  parameter int                ADDR_W    = 9,
  parameter int                KEY_W     = 6,
  parameter int unsigned       LAST_ADDR = 511,
  parameter logic [KEY_W-1:0]  END_CODE  = 6'h3F
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play,
  input  logic                  beat,
  score_playback_reader_if.master mem,
  output logic [KEY_W-1:0]      key_out,
  output logic [ADDR_W-1:0]     beat_num,
  output logic                  playing,
  output logic                  done,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CAPT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              beat_q;
  logic              beat_rise;
  logic              pending;
  logic              advance;
  logic              at_last;
  logic              end_hit;
  logic [ADDR_W-1:0] rd_addr;

  assign mem.rd_addr = rd_addr;

  assign beat_rise = beat & ~beat_q;
  // A beat can come from this cycle's edge or from one buffered while the
  // next entry was still being fetched.
  assign advance   = (state == S_HOLD) && (beat_rise || pending);
  assign at_last   = (rd_addr == ADDR_W'(LAST_ADDR));
  assign end_hit   = (mem.rd_data == END_CODE);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A low play aborts from every active state first.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (play) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (!play) state_next = S_IDLE;
        else       state_next = S_CAPT;
      end
      S_CAPT: begin
        if (!play)        state_next = S_IDLE;
        else if (end_hit) state_next = S_DONE;
        else              state_next = S_HOLD;
      end
      S_HOLD: begin
        if (!play) begin
          state_next = S_IDLE;
        end else if (advance) begin
`ifdef SCORE_LOOP_EN
          state_next = S_FETCH;
`else
          state_next = at_last ? S_DONE : S_FETCH;
`endif
        end
      end
      S_DONE: begin
        if (!play) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register, so they change only on a clock edge.
  always_comb begin
    playing   = (state == S_FETCH) || (state == S_CAPT) || (state == S_HOLD);
    done      = (state == S_DONE);
    state_dbg = state;
  end

  // Datapath: beat edge detect, pending beat, address, index and key registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      beat_q   <= 1'b0;
      pending  <= 1'b0;
      rd_addr  <= '0;
      beat_num <= '0;
      key_out  <= '0;
    end else begin
      beat_q <= beat;
      if (state_next == S_IDLE) begin
        // Entering or staying in IDLE clears everything. This also covers
        // an abort, so the tone stops at the same edge.
        pending  <= 1'b0;
        rd_addr  <= '0;
        beat_num <= '0;
        key_out  <= '0;
      end else begin
        case (state)
          S_FETCH: begin
            if (beat_rise) pending <= 1'b1;
          end
          S_CAPT: begin
            // Only one beat is buffered. A second rise here merges into it.
            if (beat_rise) pending <= 1'b1;
            key_out <= end_hit ? '0 : mem.rd_data;
          end
          S_HOLD: begin
            if (advance) begin
              pending <= 1'b0;
              if (at_last) begin
`ifdef SCORE_LOOP_EN
                rd_addr  <= '0;
                beat_num <= '0;
`else
                key_out  <= '0;
`endif
              end else begin
                rd_addr  <= rd_addr + 1'b1;
                beat_num <= beat_num + 1'b1;
              end
            end
          end
          S_DONE: begin
            key_out <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_score_playback_reader.sv
// -----------------------------------------------------------------------------
// tb_score_playback_reader
//
// Testbench for score_playback_reader. A behavioural model of the playback
// rules predicts {playing, done, rd_addr, beat_num, key_out} on every clock.
// A scoreboard compares these predictions with the DUT. Hand-computed
// checks at fixed points confirm start latency, note sequence, pending
// beat, abort and wrap/end.
// -----------------------------------------------------------------------------
module tb_score_playback_reader;

  localparam int ADDR_W = 9;
  localparam int KEY_W  = 6;
  localparam int LAST   = 511;
  localparam logic [KEY_W-1:0] END_C = 6'h3F;
  localparam int EW = 2 + 2*ADDR_W + KEY_W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic play  = 1'b0;
  logic beat  = 1'b0;

  always #5 clk = ~clk;

  logic [KEY_W-1:0]  key_out;
  logic [ADDR_W-1:0] beat_num;
  logic              playing;
  logic              done;
  logic [2:0]        state_dbg;

  score_playback_reader_if #(.ADDR_W(ADDR_W), .KEY_W(KEY_W)) mem_if ();

  score_playback_reader #(
    .ADDR_W(ADDR_W), .KEY_W(KEY_W), .LAST_ADDR(LAST), .END_CODE(END_C)
  ) dut (
    .clk(clk), .reset(reset), .play(play), .beat(beat), .mem(mem_if),
    .key_out(key_out), .beat_num(beat_num), .playing(playing), .done(done),
    .state_dbg(state_dbg)
  );

  // Score memory: synchronous read, one cycle latency.
  logic [KEY_W-1:0] mem [512];
  always @(posedge clk) mem_if.rd_data <= mem[mem_if.rd_addr];

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- behavioural model ----------------
  // The model tracks whether a score is playing or finished, the entry
  // address and index, the sounding key, and how many clocks remain until a
  // fetched entry reaches key_out (0 = holding).
  logic [EW-1:0] exp_q[$];
  bit            m_active, m_done, m_pend, m_beat_prev, m_rise;
  int            m_wait, m_addr, m_bn;
  logic [KEY_W-1:0] m_key;

  task automatic m_clear();
    m_active = 0; m_done = 0; m_pend = 0; m_wait = 0;
    m_addr = 0; m_bn = 0; m_key = '0;
  endtask

  initial m_clear();

  always @(posedge clk) begin
    m_rise = beat && !m_beat_prev;
    if (!reset) begin
      m_clear();
      m_beat_prev = 0;
    end else begin
      m_beat_prev = beat;
      if (!play) begin
        m_clear();
      end else if (m_done) begin
        // finished: hold silence until play drops
      end else if (!m_active) begin
        m_active = 1; m_wait = 2; m_addr = 0; m_bn = 0; m_key = '0; m_pend = 0;
      end else if (m_wait > 0) begin
        if (m_rise) m_pend = 1;
        m_wait--;
        if (m_wait == 0) begin
          if (mem[m_addr] == END_C) begin
            m_key = '0; m_done = 1; m_active = 0;
          end else begin
            m_key = mem[m_addr];
          end
        end
      end else if (m_rise || m_pend) begin
        m_pend = 0;
        if (m_addr == LAST) begin
`ifdef SCORE_LOOP_EN
          m_addr = 0; m_bn = 0; m_wait = 2;
`else
          m_done = 1; m_active = 0; m_key = '0;
`endif
        end else begin
          m_addr++; m_bn++; m_wait = 2;
        end
      end
    end
    exp_q.push_back({m_active, m_done, ADDR_W'(m_addr), ADDR_W'(m_bn), m_key});
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] exp_v, got_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {playing, done, mem_if.rd_addr, beat_num, key_out};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL cycle_model t=%0t got {play,done,addr,bnum,key}=%h expected %h",
                 $time, got_v, exp_v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic beat_cycle(input int hi, input int lo);
    beat = 1'b1; tick(hi);
    beat = 1'b0; tick(lo);
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    mem[0] = 6'd5; mem[1] = 6'd0; mem[2] = 6'd12; mem[3] = END_C;

    // Reset held with play high and beat toggling.
    reset = 1'b0; play = 1'b1;
    for (int i = 0; i < 6; i++) begin
      beat = ~beat; tick(1);
    end
    check("rst_key", key_out, 0);
    check("rst_bnum", beat_num, 0);
    check("rst_addr", mem_if.rd_addr, 0);
    check("rst_playing", playing, 0);
    check("rst_done", done, 0);

    // Start latency: mem[0] appears 3 cycles after the first edge that sees play.
    beat = 1'b0; reset = 1'b1;
    tick(1);
    check("start_playing", playing, 1);
    tick(1);
    check("start_key_early", key_out, 0);
    tick(1);
    check("start_key", key_out, 5);

    // Note sequence with a 64-cycle beat.
    beat_cycle(32, 32);
    check("seq1_key", key_out, 0);
    check("seq1_bnum", beat_num, 1);
    beat_cycle(32, 32);
    check("seq2_key", key_out, 12);
    check("seq2_bnum", beat_num, 2);
    beat = 1'b1; tick(2);
    check("seq_done_early", done, 0);
    tick(1);
    check("seq_done", done, 1);
    check("seq_done_key", key_out, 0);
    check("seq_done_bnum", beat_num, 3);
    beat = 1'b0; tick(4);

    // Abort while key 12 sounds, then restart at address 0.
    play = 1'b0; tick(1);
    play = 1'b1; tick(3);
    beat_cycle(4, 4);
    beat_cycle(4, 4);
    check("abort_pre_key", key_out, 12);
    play = 1'b0; tick(1);
    check("abort_key", key_out, 0);
    check("abort_playing", playing, 0);
    check("abort_addr", mem_if.rd_addr, 0);
    play = 1'b1; tick(3);
    check("restart_key", key_out, 5);
    check("restart_bnum", beat_num, 0);

    // Pending beat: rise while the first entry is being fetched.
    play = 1'b0; tick(2);
    mem[0] = 6'd9; mem[1] = 6'd3;
    play = 1'b1; tick(1);
    beat = 1'b1; tick(1);
    tick(2);
    check("pend_bnum", beat_num, 1);
    tick(2);
    check("pend_key", key_out, 3);
    tick(10);
    check("pend_bnum_hold", beat_num, 1);

    // Wrap / end of memory: all entries 7, no END_CODE.
    play = 1'b0; beat = 1'b0; tick(2);
    for (int i = 0; i < 512; i++) mem[i] = 6'd7;
    play = 1'b1; tick(3);
    repeat (511) beat_cycle(3, 3);
    check("wrap_pre_bnum", beat_num, 511);
    check("wrap_pre_addr", mem_if.rd_addr, 511);
    beat = 1'b1; tick(4);
`ifdef SCORE_LOOP_EN
    check("wrap_bnum", beat_num, 0);
    check("wrap_addr", mem_if.rd_addr, 0);
    check("wrap_key", key_out, 7);
    check("wrap_done", done, 0);
`else
    check("wrap_done", done, 1);
    check("wrap_key", key_out, 0);
    check("wrap_playing", playing, 0);
`endif

    // Randomized segments: random scores, beats, aborts and resets.
    for (int seg = 0; seg < 12; seg++) begin
      play = 1'b0; beat = 1'b0; reset = 1'b1; tick(2);
      for (int i = 0; i < 512; i++) mem[i] = KEY_W'($urandom_range(0, 62));
      if ($urandom_range(0, 3) != 0) mem[$urandom_range(1, 15)] = END_C;
      play = 1'b1;
      for (int c = 0, n = $urandom_range(60, 250); c < n; c++) begin
        if ($urandom_range(0, 2) == 0) beat = ~beat;
        play  = ($urandom_range(0, 99) != 0);
        reset = ($urandom_range(0, 199) != 0);
        tick(1);
      end
    end
    reset = 1'b1; play = 1'b0; tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
